mem_access_unit: RTL

//  Sequencing load/store unit for the MEM stage. Accepts one LW/SW/LB/LBU/SB request at a time and

---
 rtl/mem_access_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Sequencing load/store unit between the MEM stage and a word-wide synchronous data RAM.
// Handles LW/LB/LBU/SW directly and performs SB as a read-modify-write of the containing word.
module mem_access_unit #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic              req_byte,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_RDW,
      S_WR,
      S_RSP
   } state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic              byte_q, byte_d;
   logic              signed_q, signed_d;
   logic [ADDR_W+1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              accept;
   logic              req_bad;
   logic [7:0]        lane_byte;
   logic [31:0]       merged;

   assign accept  = req_valid && (state_q == S_IDLE) && !rst;
   assign req_bad = (!req_byte && (req_addr[1:0] != 2'b00)) ||
                    (req_addr[31:ADDR_W+2] != '0);

   // Big-endian lanes: offset 0 is the most significant byte of the word.
   always_comb begin
      lane_byte = '0;
      merged    = mem_rdata;
      case (addr_q[1:0])
         2'd0: begin
            lane_byte     = mem_rdata[31:24];
            merged[31:24] = wdata_q[7:0];
         end
         2'd1: begin
            lane_byte     = mem_rdata[23:16];
            merged[23:16] = wdata_q[7:0];
         end
         2'd2: begin
            lane_byte     = mem_rdata[15:8];
            merged[15:8]  = wdata_q[7:0];
         end
         default: begin
            lane_byte     = mem_rdata[7:0];
            merged[7:0]   = wdata_q[7:0];
         end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      byte_d   = byte_q;
      signed_d = signed_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               we_d     = req_we;
               byte_d   = req_byte;
               signed_d = req_signed;
               addr_d   = req_addr[ADDR_W+1:0];
               wdata_d  = req_wdata;
               if (req_bad) begin
                  rdata_d = '0;
                  err_d   = 1'b1;
                  state_d = S_RSP;
               end else if (req_we && !req_byte) begin
                  state_d = S_WR;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD: state_d = S_RDW;
         S_RDW: begin
            // SB reuses the write-data register to carry the merged word into WR.
            if (we_q) begin
               wdata_d = merged;
               state_d = S_WR;
            end else begin
               if (!byte_q) begin
                  rdata_d = mem_rdata;
               end else if (signed_q) begin
                  rdata_d = {{24{lane_byte[7]}}, lane_byte};
               end else begin
                  rdata_d = {24'b0, lane_byte};
               end
               err_d   = 1'b0;
               state_d = S_RSP;
            end
         end
         S_WR: begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = S_RSP;
         end
         S_RSP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         byte_q   <= 1'b0;
         signed_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         byte_q   <= byte_d;
         signed_q <= signed_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // Every output is held low while reset is asserted, independent of state.
   assign req_ready  = (state_q == S_IDLE) && !rst;
   assign resp_valid = (state_q == S_RSP) && !rst;
   assign resp_rdata = rst ? '0 : rdata_q;
   assign resp_err   = !rst && err_q;
   assign mem_en     = !rst && ((state_q == S_RD) || (state_q == S_WR));
   assign mem_we     = !rst && (state_q == S_WR);
   assign mem_addr   = rst ? '0 : addr_q[ADDR_W+1:2];
   assign mem_wdata  = rst ? '0 : wdata_q;

endmodule
